// File: rtl/hazard_scoreboard.sv
// Decode-stage operand hazard unit: per-register countdown scoreboard for RAW/WAW
// stalls plus a prioritised forwarding mux in front of the register file.
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int NUM_FWD  = 2,
   parameter int MAX_LAT  = 15,
   parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dec_valid,
   input  logic                        hold,
   input  logic [ADDR_W-1:0]           src_a_addr,
   input  logic [ADDR_W-1:0]           src_b_addr,
   input  logic                        src_a_used,
   input  logic                        src_b_used,
   input  logic [DATA_W-1:0]           rf_a_data,
   input  logic [DATA_W-1:0]           rf_b_data,
   input  logic                        dst_we,
   input  logic [ADDR_W-1:0]           dst_addr,
   input  logic [LAT_W-1:0]            dst_lat,
   input  logic [NUM_FWD-1:0]          fwd_we,
   input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
   output logic [DATA_W-1:0]           op_a,
   output logic [DATA_W-1:0]           op_b,
   output logic                        stall,
   output logic                        issue,
   output logic [NUM_REGS-1:0]         busy_mask,
   output logic [31:0]                 stall_count
);

   logic [LAT_W-1:0] pend_reg [NUM_REGS];
   logic [31:0]      stall_count_reg;
   logic             raw_a, raw_b, waw;

   assign raw_a = src_a_used && (pend_reg[src_a_addr] != '0);
   assign raw_b = src_b_used && (pend_reg[src_b_addr] != '0);
   // A shorter write must not retire ahead of an older, longer one to the same register.
   assign waw   = dst_we && (dst_addr != '0) && (pend_reg[dst_addr] > dst_lat);
   assign stall = dec_valid && (raw_a || raw_b || waw);
   assign issue = dec_valid && !stall && !hold;

   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rst || r == 0) begin
            pend_reg[r] <= '0;
         end else if (issue && dst_we && dst_addr == ADDR_W'(r)) begin
            pend_reg[r] <= dst_lat;
         end else if (pend_reg[r] != '0) begin
            pend_reg[r] <= pend_reg[r] - LAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count_reg <= '0;
      end else if (stall && stall_count_reg != '1) begin
         stall_count_reg <= stall_count_reg + 32'd1;
      end
   end

   assign stall_count = stall_count_reg;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         assign busy_mask[gi] = (pend_reg[gi] != '0);
      end
   endgenerate

   // Highest-index bus is applied first so the youngest (index 0) match wins.
   always_comb begin
      op_a = rf_a_data;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_we[i] && fwd_addr[i*ADDR_W +: ADDR_W] == src_a_addr) begin
            op_a = fwd_data[i*DATA_W +: DATA_W];
         end
      end
      if (src_a_addr == '0) begin
         op_a = '0;
      end
   end

   always_comb begin
      op_b = rf_b_data;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_we[i] && fwd_addr[i*ADDR_W +: ADDR_W] == src_b_addr) begin
            op_b = fwd_data[i*DATA_W +: DATA_W];
         end
      end
      if (src_b_addr == '0) begin
         op_b = '0;
      end
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised operand-hazard unit for the MIPS decode stage. It tracks every architectural register with an outstanding multi-cycle write (loads, multiply/divide, or any unit with a declared latency) in a per-register countdown scoreboard. It stalls decode on RAW and WAW hazards. It selects each source operand from N prioritised forwarding buses or the register file. It sits between the register file read ports and the decode/ALU operand muxes, and replaces the fixed EX/MEM forwarding and load-use check.

## Interface

Parameters:
- `NUM_REGS`, 32: architectural registers; index 0 is hardwired zero.
- `ADDR_W`, 5: register address width; `NUM_REGS` = 2**`ADDR_W`.
- `DATA_W`, 32: operand width.
- `NUM_FWD`, 2: forwarding buses; index 0 is the youngest stage and has the highest priority.
- `MAX_LAT`, 15: largest declarable result latency. `LAT_W` = $clog2(`MAX_LAT`+1).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `dec_valid`  in  1  decode holds a valid instruction.
- `hold`  in  1  downstream stall; instruction must not issue.
- `src_a_addr`, `src_b_addr`  in  `ADDR_W`  source register addresses (rs, rt).
- `src_a_used`, `src_b_used`  in  1  instruction actually reads that source.
- `rf_a_data`, `rf_b_data`  in  `DATA_W`  register-file read data.
- `dst_we`  in  1  instruction writes a register.
- `dst_addr`  in  `ADDR_W`  destination register.
- `dst_lat`  in  `LAT_W`  cycles after issue before the result appears on a forward bus (ALU 0, load 1).
- `fwd_we`  in  `NUM_FWD`  forward bus valid, per bus.
- `fwd_addr`  in  `NUM_FWD*ADDR_W`  forward bus destinations, packed, bus i at [i*ADDR_W +: ADDR_W].
- `fwd_data`  in  `NUM_FWD*DATA_W`  forward bus data, packed likewise.
- `op_a`, `op_b`  out  `DATA_W`  resolved operands.
- `stall`  out  1  hazard stall to decode/PC.
- `issue`  out  1  `dec_valid & ~stall & ~hold`.
- `busy_mask`  out  `NUM_REGS`  bit r set when pend[r] != 0.
- `stall_count`  out  32  hazard-stall cycle counter, saturating.

## Operation

- State: `pend[r]` (`LAT_W` bits) for r = 1..NUM_REGS-1. `pend[0]` is constant 0.
- Update each cycle, per register r:
  - If `issue & dst_we & dst_addr==r & r!=0`, then pend[r] <= dst_lat. This set overrides the decrement.
  - Else if pend[r] != 0, then pend[r] <= pend[r]-1.
- RAW hazard: `src_x_used & pend[src_x_addr] != 0`, for x = a or b.
- WAW hazard: `dst_we & dst_addr != 0 & pend[dst_addr] > dst_lat`. This prevents a shorter-latency write from completing before an older one.
- `stall` = `dec_valid & (RAW_a | RAW_b | WAW)`. It is combinational from state and inputs and does not depend on `hold`.
- Operand select for x = a or b:
  - If addr == 0, output 0.
  - Else use the lowest-index bus i with `fwd_we[i] & fwd_addr[i]==addr`.
  - Else use `rf_x_data`.
- Operand select is computed whether or not the source is used.
- `stall_count` increments by 1 on every cycle with `stall`=1. It holds at 32'hFFFF_FFFF once it reaches that value.

## Timing

- Reset (`rst`=1 at a clock edge): all pend = 0, `busy_mask` = 0, `stall_count` = 0. With `dec_valid`=0, `stall`=0 and `issue`=0.
- Reset mid-operation discards all outstanding pending state. The surrounding pipeline is flushed by the same reset.
- The scoreboard is written at the edge that ends the issue cycle t. A write with lat L makes a dependent instruction stall for exactly L cycles (t+1..t+L) and issue at t+L+1.
- `dst_lat`=0 writes never set pend. They rely on forwarding alone.
- Forward mux and `stall` have zero latency (combinational). `busy_mask` reflects registered state, one cycle after issue.
- An issue to register r in the same cycle that pend[r] reaches 1→0 loads the new latency.

## Test plan

- Reset: hold `rst` 2 cycles, then drive `dec_valid`=1, src_a=3 used, `rf_a_data`=32'h1234 → `stall`=0, `issue`=1, `op_a`=32'h1234, `busy_mask`=0, `stall_count`=0.
- Load-use: issue dst 5, lat 1; next cycle src_a=5 used → `stall`=1 for 1 cycle. The following cycle, with `fwd_we[1]`=1, `fwd_addr[1]`=5, `fwd_data[1]`=32'hDEAD_BEEF → `stall`=0, `op_a`=32'hDEAD_BEEF, `stall_count`=1.
- Multicycle: issue dst 8, lat 4; consumer on src_b=8 → `stall` high exactly 4 cycles. `busy_mask[8]` is high for 4 cycles.
- Zero register and priority:
  - Issue dst 0, lat 3 → `busy_mask`=0 and no stall on src 0; `op_a`=0 even when `fwd_addr[0]`=0 with `fwd_we[0]`=1.
  - Buses 0 and 1 both address 7, data 32'hA / 32'hB → `op_a`=32'hA.
- WAW: pend[9]=3, issue dst 9 with lat 1 → `stall`=1 until pend[9] ≤ 1, then issue. `hold`=1 with no hazard → `stall`=0, `issue`=0, pend unchanged except decrement.
- Reset mid-op: pend[12]=6, assert `rst` → next cycle `busy_mask`=0; a reader of r12 does not stall.
